// File: rtl/event_encoder.sv
// event_encoder: captures events on N = 2**WIDTH request lines into a pending
// vector and issues them one at a time as a binary index over a valid/ready
// handshake.
//   EDGE = 1 : capture rising edges; EDGE = 0 : capture levels.
//   RR   = 0 : fixed priority (lowest index); RR = 1 : round-robin.
// Optional build macro EVENT_ENCODER_DROP_CNT_EN adds an 8-bit saturating
// drop_cnt port counting events merged into an already-pending line.
module event_encoder #(
    parameter int WIDTH = 2,
    parameter int EDGE  = 1,
    parameter int RR    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2**WIDTH-1:0]   in,
    output logic [WIDTH-1:0]      out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**WIDTH-1:0]   pending,
    output logic                  busy
`ifdef EVENT_ENCODER_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int N = 2**WIDTH;

    // First set bit of vec searched upward from start, wrapping at N-1.
    // Iterating downward lets the smallest offset from start win.
    function automatic logic [WIDTH-1:0] pick_first(input logic [N-1:0] vec,
                                                    input logic [WIDTH-1:0] start);
        logic [WIDTH-1:0] idx;
        logic [WIDTH-1:0] res;
        res = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + WIDTH'(k);
            if (vec[idx]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Number of set bits in vec (at most N, fits in WIDTH+1 bits).
    function automatic logic [WIDTH:0] popcount(input logic [N-1:0] vec);
        logic [WIDTH:0] cnt;
        cnt = '0;
        for (int k = 0; k < N; k++) begin
            cnt = cnt + {{WIDTH{1'b0}}, vec[k]};
        end
        return cnt;
    endfunction

    logic [N-1:0]     in_prev_r;
    logic [N-1:0]     pending_r;
    logic [WIDTH-1:0] out_idx_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] rr_ptr_r;

    logic [N-1:0]     set_s;
    logic [N-1:0]     clr_s;
    logic [WIDTH-1:0] start_s;
    logic [WIDTH-1:0] sel_s;
    logic             load_s;
    logic             issue_s;

    // Event detection, output-stage availability and index selection.
    always_comb begin
        set_s   = (EDGE != 0) ? (in & ~in_prev_r) : in;
        load_s  = !out_valid_r || out_ready;
        start_s = (RR != 0) ? rr_ptr_r : '0;
        sel_s   = pick_first(pending_r, start_s);
        issue_s = load_s && (|pending_r);
        clr_s   = '0;
        if (issue_s) begin
            clr_s[sel_s] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Capture history, pending events, output register and round-robin pointer.
    // Set is OR-ed in after clear so a fresh event on the issued line survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_prev_r   <= in;
            pending_r   <= '0;
            out_idx_r   <= '0;
            out_valid_r <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            in_prev_r <= in;
            pending_r <= (pending_r & ~clr_s) | set_s;
            if (issue_s) begin
                out_idx_r   <= sel_s;
                out_valid_r <= 1'b1;
                rr_ptr_r    <= sel_s + WIDTH'(1'b1);
            end else if (load_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef EVENT_ENCODER_DROP_CNT_EN
    logic [7:0]       drop_cnt_r;
    logic [WIDTH:0]   drop_inc_s;
    logic [WIDTH+8:0] drop_sum_s;

    // Events that land on a line already pending (and not being cleared) merge.
    always_comb begin
        drop_inc_s = popcount(set_s & pending_r & ~clr_s);
        drop_sum_s = {{(WIDTH+1){1'b0}}, drop_cnt_r} + {8'd0, drop_inc_s};
    end

    // Saturating count of merged (dropped) events.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_sum_s > {{(WIDTH+1){1'b0}}, 8'd255}) begin
            drop_cnt_r <= 8'd255;
        end else begin
            drop_cnt_r <= drop_sum_s[7:0];
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign out_idx   = out_idx_r;
    assign out_valid = out_valid_r;
    assign pending   = pending_r;
    assign busy      = (|pending_r) || out_valid_r;

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder: a per-cycle vector table on a fixed
// priority / edge-capture instance, plus a hand-written round-robin / level
// sequence on a second instance.
module tb_event_encoder;

    logic       clk = 1'b0;
    logic       reset_a = 1'b1;
    logic [3:0] in_a = 4'd0;
    logic       ready_a = 1'b1;
    logic [1:0] idx_a;
    logic       valid_a;
    logic [3:0] pend_a;
    logic       busy_a;

    logic       reset_b = 1'b1;
    logic [3:0] in_b = 4'd0;
    logic       ready_b = 1'b1;
    logic [1:0] idx_b;
    logic       valid_b;
    logic [3:0] pend_b;
    logic       busy_b;

`ifdef EVENT_ENCODER_DROP_CNT_EN
    logic [7:0] drop_a;
    logic [7:0] drop_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    event_encoder #(.WIDTH(2), .EDGE(1), .RR(0)) dut_a (
        .clk(clk), .reset(reset_a), .in(in_a),
        .out_idx(idx_a), .out_valid(valid_a), .out_ready(ready_a),
        .pending(pend_a), .busy(busy_a)
`ifdef EVENT_ENCODER_DROP_CNT_EN
        , .drop_cnt(drop_a)
`endif
    );

    event_encoder #(.WIDTH(2), .EDGE(0), .RR(1)) dut_b (
        .clk(clk), .reset(reset_b), .in(in_b),
        .out_idx(idx_b), .out_valid(valid_b), .out_ready(ready_b),
        .pending(pend_b), .busy(busy_b)
`ifdef EVENT_ENCODER_DROP_CNT_EN
        , .drop_cnt(drop_b)
`endif
    );

    typedef struct {
        logic       rst;
        logic [3:0] in;
        logic       rdy;
        logic       v;
        logic [1:0] idx;
        logic [3:0] pend;
        logic [7:0] drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] in, input logic rdy,
                       input logic v, input logic [1:0] idx, input logic [3:0] pend,
                       input logic [7:0] drop);
        vec_t e;
        e.rst = rst; e.in = in; e.rdy = rdy;
        e.v = v; e.idx = idx; e.pend = pend; e.drop = drop;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        //   rst   in       rdy   valid idx    pending  drop
        add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 0  reset
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 1
        add(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 8'd0); // 2  pulse in[2]
        add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 8'd0); // 3  issued
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 8'd0); // 4  one cycle only
        add(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 5  reset with lines high
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 6  no spurious edge
        add(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 7
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 8
        add(1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 8'd0); // 9  raise in[1]
        add(1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 8'd0); // 10
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 8'd0); // 11
        add(1'b0, 4'b1101, 1'b0, 1'b0, 2'd1, 4'b1101, 8'd0); // 12 edges 3,2,0
        add(1'b0, 4'b1101, 1'b0, 1'b1, 2'd0, 4'b1100, 8'd0); // 13 idx0 loaded
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1100, 8'd0); // 14 held
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1100, 8'd0); // 15
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1100, 8'd0); // 16
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1100, 8'd0); // 17
        add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b1000, 8'd0); // 18 accept -> 2
        add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 8'd0); // 19 -> 3
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 8'd0); // 20
        add(1'b0, 4'b0010, 1'b0, 1'b0, 2'd3, 4'b0010, 8'd0); // 21 backpressure
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000, 8'd0); // 22 idx1 held
        add(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 8'd0); // 23 second edge on 1
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010, 8'd0); // 24
        add(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 8'd1); // 25 third edge merges
        add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 8'd1); // 26 idx1 again
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 8'd1); // 27
        add(1'b0, 4'b1000, 1'b0, 1'b0, 2'd1, 4'b1000, 8'd1); // 28
        add(1'b0, 4'b0010, 1'b0, 1'b1, 2'd3, 4'b0010, 8'd1); // 29
        add(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0010, 8'd1); // 30
        add(1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 8'd1); // 31 set wins over clear
        add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 8'd1); // 32
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 8'd1); // 33
        add(1'b0, 4'b1000, 1'b0, 1'b0, 2'd1, 4'b1000, 8'd1); // 34
        add(1'b0, 4'b0110, 1'b0, 1'b1, 2'd3, 4'b0110, 8'd1); // 35 valid, pend 0110
        add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 8'd0); // 36 reset mid-handshake
        add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0); // 37

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset_a = tbl[i].rst;
            in_a    = tbl[i].in;
            ready_a = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk("a_valid",   i, {31'd0, valid_a}, {31'd0, tbl[i].v});
            chk("a_idx",     i, {30'd0, idx_a},   {30'd0, tbl[i].idx});
            chk("a_pending", i, {28'd0, pend_a},  {28'd0, tbl[i].pend});
            chk("a_busy",    i, {31'd0, busy_a},  {31'd0, (tbl[i].v | (|tbl[i].pend))});
`ifdef EVENT_ENCODER_DROP_CNT_EN
            chk("a_drop",    i, {24'd0, drop_a},  {24'd0, tbl[i].drop});
`endif
        end

        // Round-robin, level capture: in = 1011 held, ready high.
        @(negedge clk);
        reset_b = 1'b0;
        in_b    = 4'b1011;
        ready_b = 1'b1;
        @(posedge clk);
        #1;
        chk("b_first_valid", 0, {31'd0, valid_b}, 32'd0);
        chk("b_first_pend",  0, {28'd0, pend_b},  32'd11);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("b_rr_valid", k + 1, {31'd0, valid_b}, 32'd1);
            chk("b_rr_idx",   k + 1, {30'd0, idx_b},   rr_exp[k]);
            chk("b_rr_busy",  k + 1, {31'd0, busy_b},  32'd1);
        end

        // Reset while an event is held and lines are still high.
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        chk("b_rst_valid", 7, {31'd0, valid_b}, 32'd0);
        chk("b_rst_pend",  7, {28'd0, pend_b},  32'd0);
        chk("b_rst_idx",   7, {30'd0, idx_b},   32'd0);
`ifdef EVENT_ENCODER_DROP_CNT_EN
        chk("b_rst_drop",  7, {24'd0, drop_b},  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Registered successor to the one-hot-to-binary encoder. Captures events on N = 2**WIDTH request lines (buttons, row-full flags, etc.) into a pending vector and encodes them one at a time into a binary index.
- Delivers each index through a valid/ready handshake, so no event is lost while the consumer (game FSM, display writer) is busy.
- Sits between synchronised input lines and the Tetris control logic.

Parameters:
- WIDTH, 2: index width; number of request lines N = 2**WIDTH.
- EDGE, 1: 1 = capture rising edges of in[i]; 0 = capture level (line re-requests every cycle it is high).
- RR, 0: 0 = fixed priority, lowest index wins; 1 = round-robin, search starts at last issued index + 1 (mod N).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  N  request lines, already synchronised to clk.
- out_idx  output  WIDTH  binary index of the issued event; 0-based, in[i] -> i.
- out_valid  output  1  out_idx holds an un-consumed event.
- out_ready  input  1  consumer accepts out_idx this cycle when out_valid is also high.
- pending  output  N  captured events not yet loaded into the output register.
- busy  output  1  |pending OR out_valid.

Behaviour:
- Reset (reset high at posedge):
  - pending=0, out_valid=0, out_idx=0, rr_ptr=0.
  - in_prev loads in, so lines already high at reset do not produce a spurious edge.
  - Reset has priority over every other event; a reset mid-handshake discards the held event and all pending events.
- Capture, every cycle:
  - set = EDGE ? (in & ~in_prev) : in.
  - in_prev <= in.
  - pending <= (pending & ~clr) | set. Set wins over clear on the same bit, so a new event arriving on the line being issued is kept.
- Output register load condition: load = !out_valid || out_ready.
  - When load is true and pending != 0, the select logic picks index s. On that posedge: out_idx <= s, out_valid <= 1, clr = onehot(s).
  - When load is true and pending == 0: out_valid <= 0; out_idx holds its last value.
  - When load is false: out_idx and out_valid hold, clr = 0.
- Selection: combinational on the registered pending vector only. A set arriving in the same cycle is not eligible until the next cycle.
  - RR=0: lowest set bit of pending.
  - RR=1: first set bit at or above rr_ptr, wrapping from N-1 to 0. rr_ptr <= s+1 (mod N, natural WIDTH-bit wrap) on each load.
- Latency: a rising edge on in[i] at posedge k sets pending[i] at posedge k. out_valid rises at posedge k+1 when the output stage is free. This gives 1 cycle from capture to valid and 2 edges from input change to valid.
- Throughput: one event per cycle while out_ready is held high.
- Handshake: out_idx stable while out_valid && !out_ready. out_valid never drops without a transfer (except on reset).
- A repeated edge on a line whose pending bit is already set merges into it: one issue, event dropped.
- A line that is pending and also held in the output register is allowed; the index is issued twice.
- The design is defined for WIDTH >= 1. All index arithmetic is WIDTH bits and wraps naturally.

Optional Feature:
- Macro: EVENT_ENCODER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (8 bits).
  - Increments by the number of lines (popcount, up to N per cycle) where set[i] && pending[i] && !clr[i].
  - Saturates at 255. Cleared by reset.
- Undefined: the port and counter are absent; merge behaviour is unchanged.

Test Plan:
- WIDTH=2, EDGE=1, RR=0, out_ready=1. Pulse in=4'b0100 for 1 cycle -> out_valid high exactly 1 cycle, 2 edges after the pulse, with out_idx=2; pending returns to 0.
- Hold in=4'b1111 through reset, then release reset -> no out_valid ever (in_prev suppression). Drop in to 0, then raise in[1] -> a single issue with out_idx=1.
- RR=0, out_ready=0. Same-cycle edges on in[3], in[0], in[2] -> out_idx=0 held stable for 5 cycles. Then out_ready=1 -> issue order 0, 2, 3 on consecutive cycles.
- RR=1, EDGE=0, in=4'b1011 held, out_ready=1 -> out_idx sequence 0, 1, 3, 0, 1, 3, …
- Backpressure: out_valid=1 with idx=1 and out_ready=0. New edge on in[1] -> pending[1]=1. Accept -> idx 1 issued again next cycle. Third edge on in[1] while pending[1] set -> with EVENT_ENCODER_DROP_CNT_EN, drop_cnt=1.
- Reset asserted while out_valid=1 and pending=4'b0110 -> next cycle out_valid=0, pending=0, out_idx=0, drop_cnt=0.
